uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered UART transmitter that produces the `uart_txd` line of `system`. It accepts bytes from the on-chip bus side through a write strobe and stores them in a small FIFO. It serializes them as 8N1 frames at `uart_baud_rate`, derived from `clk_freq`. Frames are sent back-to-back with no idle gap while data is queued.

## Interface
- `clk_freq`, 100000000, system clock frequency in Hz.
- `uart_baud_rate`, 1152000, line bit rate in baud.
- `fifo_depth`, 8, number of FIFO entries; must be a power of two, at least 2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to enqueue.
- `tx_wr`  in  1  write strobe; sampled on the `clk` rising edge.
- `tx_full`  out  1  FIFO holds `fifo_depth` entries.
- `tx_empty`  out  1  FIFO holds 0 entries.
- `tx_busy`  out  1  serializer is not in IDLE.
- `tx_overflow`  out  1  one-cycle pulse when a write was dropped.
- `uart_txd`  out  1  serial line; idle high.

## Operation
- Divisor D = `clk_freq` / `uart_baud_rate`, using integer truncation. The default D is 86. D must be at least 2.
- Baud counter: counts 0..D-1 and restarts at 0 on every state entry. A bit period ends when the counter reaches D-1.
- FIFO: circular buffer with read and write pointers of log2(`fifo_depth`) bits that wrap modulo the depth. A count register of log2(`fifo_depth`)+1 bits tracks occupancy.
- Writes:
  - A write with `tx_wr`=1 and count < `fifo_depth` stores `tx_data` and increments count.
  - A write while count = `fifo_depth` is dropped, even if a pop occurs in the same cycle. In that case `tx_overflow` = 1 for the next cycle only.
- Simultaneous write and pop with count between 1 and `fifo_depth`-1: count is unchanged and both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when count > 0. The head byte is popped into the shift register.
  - START: `uart_txd` = 0 for D cycles, then goes to DATA with bit index 0.
  - DATA: `uart_txd` = shift[0] (LSB first) for D cycles per bit. After each bit the register shifts right and the index increments. After bit 7 the FSM goes to STOP.
  - STOP: `uart_txd` = 1 for D cycles. At the end it goes to START, with a pop, if count > 0; otherwise it goes to IDLE.
- `uart_txd` is driven from a register and has no combinational glitches.
- `tx_full`, `tx_empty` and `tx_busy` are registered or derived from registered count and state. They reflect the state after the most recent edge.

## Timing
- Reset values, applied immediately and asynchronously:
  - `uart_txd`=1, `tx_busy`=0, `tx_empty`=1, `tx_full`=0, `tx_overflow`=0.
  - FIFO pointers and count are 0; the FSM is in IDLE.
- Reset mid-frame aborts the frame: the line returns high at once and all queued bytes are discarded.
- Write into an empty FIFO while in IDLE at edge k:
  - `tx_empty` falls after edge k.
  - Pop and START entry happen at edge k+1; `uart_txd` falls after edge k+1.
  - `tx_empty` rises again after edge k+1 if no further writes arrive.
- Frame length is exactly 10·D cycles: 1 start bit, 8 data bits, 1 stop bit.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- `tx_busy` rises with START entry. It falls on the edge that leaves STOP when the FIFO is empty.
- A write accepted during a frame occupies a FIFO slot. The FIFO therefore holds up to `fifo_depth` bytes in addition to the one being shifted out.

## Test plan
- **Single byte:** after reset, write 0x55.
  - `uart_txd` low one cycle after the write edge.
  - Then 86-cycle bits 1,0,1,0,1,0,1,0, then high for 86 cycles.
  - `tx_busy` high for exactly 860 cycles.
- **Back-to-back:** write 0xA3, 0x0F on consecutive cycles.
  - Frames are contiguous: second start bit at cycle 860 after the first start.
  - Decoded bytes are 0xA3 then 0x0F; `tx_busy` is continuous for 1720 cycles.
- **Full and overflow:** write 10 bytes 0x00..0x09 on consecutive cycles.
  - Byte 0x00 pops; `tx_full` asserts after the ninth write.
  - The tenth write (0x09) is dropped with a one-cycle `tx_overflow` pulse.
  - Line output is 0x00..0x08.
- **Write/pop collision:** fill the FIFO to 1 entry, then write on the exact STOP->START pop edge.
  - Count stays 1; `tx_empty` stays 0; no byte is lost or duplicated.
- **Reset mid-frame:** assert `rst`=0 during data bit 3 of 0xFF while 3 bytes are queued.
  - `uart_txd`=1 and `tx_empty`=1 immediately.
  - After release, no transmission occurs until a new write.
- **Pointer wrap:** stream 20 bytes 0x10..0x23, keeping the FIFO non-full.
  - Output order and values match the input exactly across pointer wrap.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered 8N1 UART transmitter. Bytes written through tx_wr/tx_data are
//   queued in a small circular FIFO and serialized LSB first on uart_txd at
//   clk_freq / uart_baud_rate clocks per bit. Queued frames go out
//   back-to-back with no idle gap.
//
// Parameters
//   clk_freq        system clock frequency in Hz
//   uart_baud_rate  line bit rate in baud
//   fifo_depth      FIFO entries (power of two, >= 2)
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   tx_data[7:0] in   byte to enqueue
//   tx_wr        in   write strobe
//   tx_full      out  FIFO holds fifo_depth entries
//   tx_empty     out  FIFO holds no entries
//   tx_busy      out  serializer not idle
//   tx_overflow  out  one-cycle pulse after a dropped write
//   uart_txd     out  registered serial line, idle high
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int unsigned clk_freq       = 100000000,
  parameter int unsigned uart_baud_rate = 1152000,
  parameter int unsigned fifo_depth     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_busy,
  output logic       tx_overflow,
  output logic       uart_txd
);

  localparam int unsigned LP_DIV = clk_freq / uart_baud_rate;
  localparam int unsigned LP_BW  = (LP_DIV > 1) ? $clog2(LP_DIV) : 1;
  localparam int unsigned LP_PW  = $clog2(fifo_depth);
  localparam int unsigned LP_CW  = LP_PW + 1;

  localparam logic [LP_BW-1:0] LP_BAUD_LAST = LP_BW'(LP_DIV - 1);
  localparam logic [LP_CW-1:0] LP_DEPTH     = LP_CW'(fifo_depth);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [LP_BW-1:0]   r_baud;
  logic               w_baud_end;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_next;
  logic               r_txd;
  logic               w_txd_next;

  logic [7:0]         r_mem [fifo_depth];
  logic [LP_PW-1:0]   r_wr_ptr;
  logic [LP_PW-1:0]   r_rd_ptr;
  logic [LP_CW-1:0]   r_count;
  logic               r_ovf;

  logic               w_full;
  logic               w_empty;
  logic               w_wr_ok;
  logic               w_pop;

  // -------------------------------------------------------------------------
  // FIFO status and write acceptance. A write against a full FIFO is dropped
  // even when a pop happens on the same edge.
  // -------------------------------------------------------------------------
  assign w_full   = (r_count == LP_DEPTH);
  assign w_empty  = (r_count == '0);
  assign w_wr_ok  = tx_wr && !w_full;

  assign w_baud_end = (r_baud == LP_BAUD_LAST);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and pop request
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_next = S_START;
          w_pop        = 1'b1;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_end && (r_bit_idx == 3'd7)) begin
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          if (!w_empty) begin
            w_state_next = S_START;
            w_pop        = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. The line level is computed from the state being entered so
  // that the registered uart_txd changes on the same edge as the state.
  // -------------------------------------------------------------------------
  always_comb begin
    w_shift_next = r_shift;
    if (w_pop) begin
      w_shift_next = r_mem[r_rd_ptr];
    end else if ((r_state == S_DATA) && w_baud_end) begin
      w_shift_next = {1'b0, r_shift[7:1]};
    end

    case (w_state_next)
      S_START: w_txd_next = 1'b0;
      S_DATA:  w_txd_next = w_shift_next[0];
      default: w_txd_next = 1'b1;
    endcase
  end

  // -------------------------------------------------------------------------
  // Serializer datapath. The baud counter restarts on every bit boundary,
  // which coincides with every state entry; in IDLE it is held at zero.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else begin
      if ((r_state == S_IDLE) || w_baud_end) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + 1'b1;
      end

      if (r_state == S_START) begin
        r_bit_idx <= '0;
      end else if ((r_state == S_DATA) && w_baud_end) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end

      r_shift <= w_shift_next;
      r_txd   <= w_txd_next;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO storage (no reset needed; validity is tracked by r_count)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointers, occupancy and overflow flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      case ({w_wr_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      r_ovf <= tx_wr && w_full;
    end
  end

  assign tx_full     = w_full;
  assign tx_empty    = w_empty;
  assign tx_busy     = (r_state != S_IDLE);
  assign tx_overflow = r_ovf;
  assign uart_txd    = r_txd;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int BIT   = 86;
  localparam int FRAME = 860;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_busy;
  logic       tx_overflow;
  logic       uart_txd;

  uart_tx_fifo #(
    .clk_freq       (100000000),
    .uart_baud_rate (1152000),
    .fifo_depth     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_full     (tx_full),
    .tx_empty    (tx_empty),
    .tx_busy     (tx_busy),
    .tx_overflow (tx_overflow),
    .uart_txd    (uart_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line monitor: one record per complete frame, mid-bit samples {stop,d7..d0,start}
  typedef struct {
    logic [9:0] raw;
    int         t0;
  } rx_t;

  rx_t rx_q[$];

  initial begin : monitor
    rx_t r;
    bit  ab;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && uart_txd === 1'b0) begin
        r.t0  = cyc;
        r.raw = '0;
        ab    = 1'b0;
        for (int c = 1; c < FRAME; c++) begin
          @(negedge clk);
          if (rst !== 1'b1) ab = 1'b1;
          if ((c % BIT) == BIT / 2) r.raw[c / BIT] = uart_txd;
        end
        if (!ab) rx_q.push_back(r);
      end
    end
  end

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr   = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output int len);
    len = 0;
    while (tx_busy === 1'b1 && len < maxc) begin
      @(negedge clk);
      len++;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t tbl[5];

  initial begin : watchdog
    #5ms;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin : main
    int len;
    int t_start;
    int n;
    int bad;
    int ovf_seen;

    tbl[0] = '{8'h55, 10'b1010101010};
    tbl[1] = '{8'hA3, 10'b1101000110};
    tbl[2] = '{8'h0F, 10'b1000011110};
    tbl[3] = '{8'h80, 10'b1100000000};
    tbl[4] = '{8'h01, 10'b1000000010};

    tx_data = '0;
    tx_wr   = 1'b0;
    rst     = 1'b1;
    #2 rst  = 1'b0;
    #1;
    chk("reset_txd",      uart_txd,    1);
    chk("reset_busy",     tx_busy,     0);
    chk("reset_empty",    tx_empty,    1);
    chk("reset_full",     tx_full,     0);
    chk("reset_overflow", tx_overflow, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // single-byte frames
    for (int i = 0; i < 5; i++) begin
      rx_q.delete();
      write_byte(tbl[i].data);
      chk("single_empty_after_wr", tx_empty, 0);
      chk("single_txd_before_start", uart_txd, 1);
      @(negedge clk);
      t_start = cyc;
      chk("single_txd_start", uart_txd, 0);
      chk("single_busy_start", tx_busy, 1);
      chk("single_empty_after_pop", tx_empty, 1);
      wait_idle(2000, len);
      chk("single_busy_len", len, FRAME);
      chk("single_txd_idle", uart_txd, 1);
      @(negedge clk);
      chk("single_rx_count", rx_q.size(), 1);
      if (rx_q.size() > 0) begin
        chk("single_rx_frame", rx_q[0].raw, tbl[i].frame);
        chk("single_rx_t0", rx_q[0].t0, t_start);
      end
      repeat (5) @(negedge clk);
    end

    // back-to-back: 0xA3 then 0x0F on consecutive cycles
    rx_q.delete();
    @(negedge clk); tx_data = 8'hA3; tx_wr = 1'b1;
    @(negedge clk); tx_data = 8'h0F;
    @(negedge clk); tx_wr = 1'b0;
    t_start = cyc;
    chk("b2b_txd_start", uart_txd, 0);
    chk("b2b_empty", tx_empty, 0);
    wait_idle(4000, len);
    chk("b2b_busy_len", len, 2 * FRAME);
    @(negedge clk);
    chk("b2b_rx_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("b2b_frame0", rx_q[0].raw, 10'b1101000110);
      chk("b2b_frame1", rx_q[1].raw, 10'b1000011110);
      chk("b2b_t0", rx_q[0].t0, t_start);
      chk("b2b_gap", rx_q[1].t0 - rx_q[0].t0, FRAME);
    end
    repeat (5) @(negedge clk);

    // full and overflow: ten writes on consecutive cycles
    rx_q.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 1) chk("ovf_empty_after_first", tx_empty, 0);
      if (i == 8) chk("ovf_not_full_7", tx_full, 0);
      if (i == 9) begin
        chk("ovf_full_8", tx_full, 1);
        chk("ovf_no_pulse_yet", tx_overflow, 0);
      end
      tx_data = 8'(i);
      tx_wr   = 1'b1;
    end
    @(negedge clk);
    tx_wr = 1'b0;
    chk("ovf_pulse", tx_overflow, 1);
    chk("ovf_still_full", tx_full, 1);
    @(negedge clk);
    chk("ovf_pulse_end", tx_overflow, 0);
    wait_idle(9 * FRAME + 200, len);
    chk("ovf_drained", tx_busy, 0);
    @(negedge clk);
    chk("ovf_rx_count", rx_q.size(), 9);
    for (int j = 0; j < 9 && j < rx_q.size(); j++) begin
      chk("ovf_rx_data", rx_q[j].raw[8:1], j);
    end
    repeat (5) @(negedge clk);

    // write exactly on the STOP->START pop edge
    rx_q.delete();
    write_byte(8'h3C);
    @(negedge clk);
    t_start = cyc;
    tx_data = 8'hC5;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    chk("col_queued", tx_empty, 0);
    repeat (FRAME - 2) @(negedge clk);
    chk("col_pre_stop_txd", uart_txd, 1);
    chk("col_pre_busy", tx_busy, 1);
    tx_data = 8'h96;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    chk("col_empty_stays0", tx_empty, 0);
    chk("col_full", tx_full, 0);
    chk("col_next_start", uart_txd, 0);
    wait_idle(3000, len);
    chk("col_busy_len", len, 2 * FRAME);
    @(negedge clk);
    chk("col_rx_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      chk("col_rx0", rx_q[0].raw, 10'b1001111000);
      chk("col_rx1", rx_q[1].raw, 10'b1110001010);
      chk("col_rx2", rx_q[2].raw, 10'b1100101100);
      chk("col_t0", rx_q[0].t0, t_start);
      chk("col_gap", rx_q[2].t0 - rx_q[1].t0, FRAME);
    end
    repeat (5) @(negedge clk);

    // reset during data bit 3 of 0xFF with three bytes queued
    rx_q.delete();
    write_byte(8'hFF);
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      tx_data = 8'h61 + 8'(j);
      tx_wr   = 1'b1;
      @(negedge clk);
    end
    tx_wr = 1'b0;
    chk("rst_queued", tx_empty, 0);
    repeat (377) @(negedge clk);
    chk("rst_busy_before", tx_busy, 1);
    rst = 1'b0;
    #1;
    chk("rst_txd", uart_txd, 1);
    chk("rst_empty", tx_empty, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_full", tx_full, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || tx_empty !== 1'b1) bad++;
    end
    chk("rst_quiet_cycles_bad", bad, 0);
    chk("rst_rx_none", rx_q.size(), 0);
    write_byte(8'h5A);
    @(negedge clk);
    chk("rst_new_start", uart_txd, 0);
    wait_idle(2000, len);
    @(negedge clk);
    chk("rst_new_rx_count", rx_q.size(), 1);
    if (rx_q.size() == 1) chk("rst_new_frame", rx_q[0].raw, 10'b1010110100);
    repeat (5) @(negedge clk);

    // pointer wrap: 20 bytes, next one queued whenever the FIFO drains
    rx_q.delete();
    ovf_seen = 0;
    for (int i = 0; i < 20; i++) begin
      n = 0;
      while (tx_empty !== 1'b1 && n < 2000) begin
        @(negedge clk);
        n++;
        if (tx_overflow === 1'b1) ovf_seen++;
      end
      write_byte(8'h10 + 8'(i));
      if (tx_overflow === 1'b1) ovf_seen++;
    end
    @(negedge clk);
    wait_idle(3000, len);
    chk("wrap_drained", tx_busy, 0);
    @(negedge clk);
    chk("wrap_overflow", ovf_seen, 0);
    chk("wrap_rx_count", rx_q.size(), 20);
    for (int j = 0; j < 20 && j < rx_q.size(); j++) begin
      chk("wrap_rx_data", rx_q[j].raw[8:1], 32'h10 + j);
      chk("wrap_rx_framing", {rx_q[j].raw[9], rx_q[j].raw[0]}, 2'b10);
    end
    for (int j = 1; j < rx_q.size(); j++) begin
      chk("wrap_gap", rx_q[j].t0 - rx_q[j-1].t0, FRAME);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
